// File: rtl/cache_line_xfer.sv
// ---------------------------------------------------------------------------
// cache_line_xfer
//
// Line-transfer engine that sits between the direct-mapped cache controller
// and the four-banked main memory. On request it writes back a dirty 4-word
// line (evict), fetches a 4-word line (fill), or does evict followed by fill.
// Word accesses are issued one per cycle in order k = 0..3, each waiting for
// its bank (address[2:1] == k) to be free and for the memory not to stall.
// Fill returns come back MEM_LAT cycles after issue and are written into the
// cache array at the word offset carried alongside them in a small pipeline.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start_fill/evict  requests, sampled only while idle
//   fill_addr         line to fetch            (bits [2:0] ignored)
//   evict_addr        line to write back       (bits [2:0] ignored)
//   cache_offset      byte offset into the cache line ({word,1'b0})
//   cache_rd_data     cache array word at cache_offset (same cycle)
//   cache_wr_data/en  fill data written into the cache array
//   mem_addr          word address to memory
//   mem_wr_data       write data to memory
//   mem_wr / mem_rd   memory write / read issue strobes
//   mem_rd_data       memory read return data
//   mem_busy          per-bank busy, bank = address[2:1]
//   mem_stall         memory accepts no issue this cycle
//   mem_err           memory error strobe
//   busy              engine not idle
//   done              one-cycle completion pulse
//   err               with done: a memory error was seen during the transfer
// ---------------------------------------------------------------------------
module cache_line_xfer #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_fill,
    input  logic              start_evict,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [ADDR_W-1:0] evict_addr,
    output logic [2:0]        cache_offset,
    input  logic [DATA_W-1:0] cache_rd_data,
    output logic [DATA_W-1:0] cache_wr_data,
    output logic              cache_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic [3:0]        mem_busy,
    input  logic              mem_stall,
    input  logic              mem_err,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LINE_W = ADDR_W - 3;
    // Marks the pipeline stage whose entry is being returned this cycle.
    localparam logic [MEM_LAT-1:0] HEAD_BIT = MEM_LAT'(1) << (MEM_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVICT,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               k_q, k_d;
    logic [LINE_W-1:0]        fill_line_q, fill_line_d;
    logic [LINE_W-1:0]        evict_line_q, evict_line_d;
    logic                     fill_pend_q, fill_pend_d;
    logic                     err_flag_q, err_flag_d;
    logic [MEM_LAT-1:0]       pipe_vld_q, pipe_vld_d;
    logic [MEM_LAT-1:0][1:0]  pipe_idx_q, pipe_idx_d;

    logic       push;
    logic       issue_ok;
    logic       head_vld;
    logic [1:0] head_idx;
    logic       later_vld;
    logic       unused_addr_bits;

    // Low address bits select a byte/word inside the line and are regenerated
    // from k, so the latched copies drop them.
    assign unused_addr_bits = ^{fill_addr[2:0], evict_addr[2:0]};

    // Word k always lives in bank k because the bank is address[2:1].
    assign issue_ok  = !mem_stall && !mem_busy[k_q];
    assign head_vld  = pipe_vld_q[MEM_LAT-1];
    assign head_idx  = pipe_idx_q[MEM_LAT-1];
    // Any read still in flight behind the one returning this cycle.
    assign later_vld = |(pipe_vld_q & ~HEAD_BIT);

    // Return pipeline: each read issue enters stage 0 tagged with its word
    // index and reaches the last stage exactly when its data is on mem_rd_data.
    generate
        for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_in
                assign pipe_vld_d[gi] = push;
                assign pipe_idx_d[gi] = k_q;
            end else begin : g_shift
                assign pipe_vld_d[gi] = pipe_vld_q[gi-1];
                assign pipe_idx_d[gi] = pipe_idx_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            k_q          <= 2'd0;
            fill_line_q  <= '0;
            evict_line_q <= '0;
            fill_pend_q  <= 1'b0;
            err_flag_q   <= 1'b0;
            pipe_vld_q   <= '0;
            pipe_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            fill_line_q  <= fill_line_d;
            evict_line_q <= evict_line_d;
            fill_pend_q  <= fill_pend_d;
            err_flag_q   <= err_flag_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_idx_q   <= pipe_idx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        fill_line_d   = fill_line_q;
        evict_line_d  = evict_line_q;
        fill_pend_d   = fill_pend_q;
        push          = 1'b0;
        cache_offset  = 3'd0;
        cache_wr_data = '0;
        cache_wr_en   = 1'b0;
        mem_addr      = '0;
        mem_wr_data   = '0;
        mem_wr        = 1'b0;
        mem_rd        = 1'b0;
        busy          = (state_q != ST_IDLE);
        done          = 1'b0;
        err           = 1'b0;

        // Sticky over the transfer; cleared as the engine returns to idle so
        // the next transfer starts clean.
        if (state_q == ST_IDLE || state_q == ST_DONE) begin
            err_flag_d = 1'b0;
        end else begin
            err_flag_d = err_flag_q | mem_err;
        end

        case (state_q)
            ST_IDLE: begin
                k_d = 2'd0;
                if (start_evict) begin
                    evict_line_d = evict_addr[ADDR_W-1:3];
                    fill_line_d  = fill_addr[ADDR_W-1:3];
                    fill_pend_d  = start_fill;
                    state_d      = ST_EVICT;
                end else if (start_fill) begin
                    fill_line_d  = fill_addr[ADDR_W-1:3];
                    fill_pend_d  = 1'b0;
                    state_d      = ST_FILL;
                end
            end

            ST_EVICT: begin
                // Address and data stay on the bus while blocked; only the
                // strobe waits for the issue condition.
                mem_addr     = {evict_line_q, k_q, 1'b0};
                cache_offset = {k_q, 1'b0};
                mem_wr_data  = cache_rd_data;
                if (issue_ok) begin
                    mem_wr = 1'b1;
                    k_d    = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d     = fill_pend_q ? ST_FILL : ST_DONE;
                        fill_pend_d = 1'b0;
                    end
                end
            end

            ST_FILL: begin
                mem_addr = {fill_line_q, k_q, 1'b0};
                if (issue_ok) begin
                    mem_rd = 1'b1;
                    push   = 1'b1;
                    k_d    = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // Leave once nothing remains behind the word returning now.
                if (!later_vld) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                err     = err_flag_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Fill returns. Evict never overlaps returns, so taking over
        // cache_offset here cannot clash with the write-back path.
        if ((state_q == ST_FILL || state_q == ST_DRAIN) && head_vld) begin
            cache_wr_en   = 1'b1;
            cache_offset  = {head_idx, 1'b0};
            cache_wr_data = mem_rd_data;
        end
    end

endmodule

// File: tb/tb_cache_line_xfer.sv
// ---------------------------------------------------------------------------
// tb_cache_line_xfer
//
// Directed and randomized checks of cache_line_xfer. The bench owns a word
// memory and the 4-word cache array. Expected behaviour comes from a
// transaction-level model: a queue of pending word operations (writes, then
// reads), each issued the first cycle neither stalled nor bank-busy, with
// returns due MEM_LAT cycles after their read and done following the last
// write or the last return.
// ---------------------------------------------------------------------------
module tb_cache_line_xfer;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_fill;
    logic              start_evict;
    logic [ADDR_W-1:0] fill_addr;
    logic [ADDR_W-1:0] evict_addr;
    logic [2:0]        cache_offset;
    logic [DATA_W-1:0] cache_rd_data;
    logic [DATA_W-1:0] cache_wr_data;
    logic              cache_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rd_data;
    logic [3:0]        mem_busy;
    logic              mem_stall;
    logic              mem_err;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    cache_line_xfer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_fill   (start_fill),
        .start_evict  (start_evict),
        .fill_addr    (fill_addr),
        .evict_addr   (evict_addr),
        .cache_offset (cache_offset),
        .cache_rd_data(cache_rd_data),
        .cache_wr_data(cache_wr_data),
        .cache_wr_en  (cache_wr_en),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr       (mem_wr),
        .mem_rd       (mem_rd),
        .mem_rd_data  (mem_rd_data),
        .mem_busy     (mem_busy),
        .mem_stall    (mem_stall),
        .mem_err      (mem_err),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
    } op_t;

    typedef struct {
        int          cyc;
        logic [1:0]  k;
        logic [15:0] data;
    } ret_t;

    logic [15:0] mem_model [0:32767];
    logic [15:0] cache_model [0:3];
    bit          ret_v [int];
    logic [15:0] ret_a [int];
    int          cyc;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Memory returns and cache array reads as seen by the DUT this cycle.
    task automatic drive_env();
        if (ret_v.exists(cyc)) mem_rd_data = mem_model[ret_a[cyc][15:1]];
        else                   mem_rd_data = 16'($urandom);
        #1;
        cache_rd_data = cache_model[cache_offset[2:1]];
        #1;
    endtask

    // Apply this cycle's accepted accesses to the bench memory/cache.
    task automatic commit_env();
        if (mem_rd === 1'b1) begin
            ret_v[cyc + MEM_LAT] = 1'b1;
            ret_a[cyc + MEM_LAT] = mem_addr;
        end
        if (mem_wr === 1'b1)      mem_model[mem_addr[15:1]] = mem_wr_data;
        if (cache_wr_en === 1'b1) cache_model[cache_offset[2:1]] = cache_wr_data;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_xfer(input bit ev, input bit fl,
                            input logic [15:0] ea, input logic [15:0] fa,
                            input bit rnd, input int err_c,
                            input logic [3:0] bmask, input int b_from, input int b_len,
                            input int restart_c,
                            output int done_c, output bit err_o);
        op_t  ops[$];
        ret_t rets[$];
        op_t  op;
        bit   pend, blk, e_wr, e_rd, e_ret, e_busy, err_seen, finished;
        int   exp_done;
        done_c   = -1;
        err_o    = 1'b0;
        exp_done = -1;
        err_seen = 1'b0;
        finished = 1'b0;
        if (ev) for (int k = 0; k < 4; k++)
            ops.push_back('{1'b1, {ea[15:3], 2'(k), 1'b0}, cache_model[k]});
        if (fl) for (int k = 0; k < 4; k++)
            ops.push_back('{1'b0, {fa[15:3], 2'(k), 1'b0}, 16'h0});
        for (int c = 0; c < 400; c++) begin
            if (c == 0) begin
                start_evict = ev;
                start_fill  = fl;
                evict_addr  = ea;
                fill_addr   = fa;
            end else begin
                evict_addr = 16'($urandom);
                fill_addr  = 16'($urandom);
                if (rnd && (exp_done < 0 || c <= exp_done)) begin
                    start_evict = ($urandom_range(0, 7) == 0);
                    start_fill  = ($urandom_range(0, 7) == 0);
                end else begin
                    start_evict = 1'b0;
                    start_fill  = (c == restart_c);
                end
            end
            if (rnd) begin
                mem_stall = ($urandom_range(0, 3) == 0);
                mem_busy  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                mem_err   = ($urandom_range(0, 19) == 0);
            end else begin
                mem_stall = 1'b0;
                mem_busy  = (c >= b_from && c < b_from + b_len) ? bmask : 4'h0;
                mem_err   = (c == err_c);
            end
            if (c >= 1 && (exp_done < 0 || c < exp_done)) err_seen |= mem_err;
            drive_env();

            pend = (c >= 1) && (ops.size() > 0);
            blk  = 1'b0;
            if (pend) begin
                op  = ops[0];
                blk = mem_stall || mem_busy[op.addr[2:1]];
            end
            e_wr   = pend && !blk && op.wr;
            e_rd   = pend && !blk && !op.wr;
            e_busy = (c >= 1) && (exp_done < 0 || c <= exp_done);
            e_ret  = (rets.size() > 0) && (rets[0].cyc == c);

            chk("busy", busy, e_busy);
            chk("mem_wr", mem_wr, e_wr);
            chk("mem_rd", mem_rd, e_rd);
            if (pend) chk("mem_addr", mem_addr, op.addr);
            if (pend && op.wr) begin
                chk("evict_offset", cache_offset, op.addr[2:0]);
                chk("mem_wr_data", mem_wr_data, op.data);
            end
            chk("cache_wr_en", cache_wr_en, e_ret);
            if (e_ret) begin
                chk("fill_offset", cache_offset, {rets[0].k, 1'b0});
                chk("cache_wr_data", cache_wr_data, rets[0].data);
                void'(rets.pop_front());
            end
            chk("done", done, (c == exp_done));
            if (c == exp_done) chk("err_at_done", err, err_seen);
            if (done === 1'b1 && done_c < 0) begin
                done_c = c;
                err_o  = err;
            end
            commit_env();

            if (e_rd) rets.push_back('{c + MEM_LAT, op.addr[2:1], mem_model[op.addr[15:1]]});
            if (e_wr || e_rd) begin
                void'(ops.pop_front());
                if (ops.size() == 0) exp_done = e_wr ? c + 1 : c + MEM_LAT + 1;
            end
            advance();
            if (exp_done >= 0 && c == exp_done + 1) begin
                finished = 1'b1;
                break;
            end
        end
        chk("xfer_finished", finished, 1'b1);
        start_evict = 1'b0;
        start_fill  = 1'b0;
        mem_err     = 1'b0;
        mem_busy    = 4'h0;
        mem_stall   = 1'b0;
    endtask

    initial begin
        int dc;
        bit eo;
        bit ev, fl;
        total       = 0;
        bad         = 0;
        cyc         = 0;
        rst         = 1'b1;
        start_fill  = 1'b0;
        start_evict = 1'b0;
        fill_addr   = '0;
        evict_addr  = '0;
        mem_busy    = 4'h0;
        mem_stall   = 1'b0;
        mem_err     = 1'b0;
        mem_rd_data = '0;
        cache_rd_data = '0;
        for (int i = 0; i < 32768; i++) mem_model[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) cache_model[i] = 16'($urandom);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_cache_wr_en", cache_wr_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        rst = 1'b0;
        advance();

        // Fill only: 0x1238, word at 0x123C holds 0xBEEF
        mem_model[16'h123C >> 1] = 16'hBEEF;
        run_xfer(1'b0, 1'b1, 16'h0, 16'h1238, 1'b0, -1, 4'h0, 0, 0, -1, dc, eo);
        chk("fill_done_cycle", dc, 7);
        chk("fill_err", eo, 1'b0);
        chk("fill_word2", cache_model[2], 16'hBEEF);

        // Evict + fill
        cache_model[0] = 16'hAAAA;
        cache_model[1] = 16'hBBBB;
        cache_model[2] = 16'hCCCC;
        cache_model[3] = 16'hDDDD;
        run_xfer(1'b1, 1'b1, 16'h4000, 16'h8000, 1'b0, -1, 4'h0, 0, 0, -1, dc, eo);
        chk("evfill_done_cycle", dc, 11);
        chk("evfill_mem_4004", mem_model[16'h4004 >> 1], 16'hCCCC);
        chk("evfill_cache_w3", cache_model[3], mem_model[16'h8006 >> 1]);

        // Bank 2 busy for cycles 3..5 of a fill
        run_xfer(1'b0, 1'b1, 16'h0, 16'h2230, 1'b0, -1, 4'b0100, 3, 3, -1, dc, eo);
        chk("busy_done_cycle", dc, 10);

        // Start pulse while busy is ignored
        run_xfer(1'b0, 1'b1, 16'h0, 16'h3000, 1'b0, -1, 4'h0, 0, 0, 2, dc, eo);
        chk("restart_done_cycle", dc, 7);

        // Memory error during evict, then a clean transfer
        run_xfer(1'b1, 1'b0, 16'h5000, 16'h0, 1'b0, 3, 4'h0, 0, 0, -1, dc, eo);
        chk("merr_done_cycle", dc, 5);
        chk("merr_err", eo, 1'b1);
        run_xfer(1'b1, 1'b0, 16'h5008, 16'h0, 1'b0, -1, 4'h0, 0, 0, -1, dc, eo);
        chk("after_merr_err", eo, 1'b0);

        // Reset in cycle 4 of a fill
        fill_addr  = 16'h6008;
        start_fill = 1'b1;
        drive_env();
        commit_env();
        advance();
        start_fill = 1'b0;
        for (int i = 1; i < 4; i++) begin
            drive_env();
            commit_env();
            advance();
        end
        drive_env();
        chk("rstmid_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_mem_rd", mem_rd, 1'b0);
        chk("rstmid_mem_addr", mem_addr, 16'h0);
        chk("rstmid_cache_wr_en", cache_wr_en, 1'b0);
        chk("rstmid_done", done, 1'b0);
        advance();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_env();
            chk("rstpost_cache_wr_en", cache_wr_en, 1'b0);
            chk("rstpost_done", done, 1'b0);
            chk("rstpost_busy", busy, 1'b0);
            chk("rstpost_mem_rd", mem_rd, 1'b0);
            commit_env();
            advance();
        end
        run_xfer(1'b0, 1'b1, 16'h0, 16'h6010, 1'b0, -1, 4'h0, 0, 0, -1, dc, eo);
        chk("rstpost_fill_done_cycle", dc, 7);

        // Randomized transfers with stalls, busy banks, errors and stray starts
        for (int t = 0; t < 24; t++) begin
            ev = 1'($urandom_range(0, 1));
            fl = ev ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int i = 0; i < 4; i++) cache_model[i] = 16'($urandom);
            run_xfer(ev, fl, 16'($urandom), 16'($urandom), 1'b1, -1, 4'h0, 0, 0, -1, dc, eo);
            chk("rnd_done_seen", (dc >= 0), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_line_xfer.md
Name: cache_line_xfer

Overview:
- Line-transfer engine between the direct-mapped cache controller FSM and the four-banked main memory.
- On a controller request it writes back a dirty 4-word line (evict), fetches a 4-word line (fill), or does both.
- It sequences per-word bank accesses, honours per-bank busy, returns fill data into the cache array by word offset, and reports done/err to the controller.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- MEM_LAT, 2, cycles from a read issue to valid mem_data_in (range 1..4).

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- start_fill, input, 1, request line fetch of fill_addr.
- start_evict, input, 1, request line writeback to evict_addr.
- fill_addr, input, ADDR_W, fill line address; bits [2:0] ignored.
- evict_addr, input, ADDR_W, victim line address (stored tag+index); bits [2:0] ignored.
- cache_offset, output, 3, word offset into cache line ({word,1'b0}).
- cache_rd_data, input, DATA_W, cache array data at cache_offset; combinational, same cycle.
- cache_wr_data, output, DATA_W, fill data to the cache array.
- cache_wr_en, output, 1, write cache_wr_data at cache_offset.
- mem_addr, output, ADDR_W, word address to memory.
- mem_wr_data, output, DATA_W, write data to memory.
- mem_wr, output, 1, memory write issue.
- mem_rd, output, 1, memory read issue.
- mem_rd_data, input, DATA_W, memory read return data.
- mem_busy, input, 4, per-bank busy; bank = address[2:1].
- mem_stall, input, 1, memory cannot accept any issue this cycle.
- mem_err, input, 1, memory error strobe.
- busy, output, 1, engine active (not IDLE).
- done, output, 1, one-cycle completion pulse.
- err, output, 1, one-cycle pulse coincident with done if mem_err was seen during the transfer.

Behaviour:
- Reset: state IDLE; all outputs 0; return pipeline cleared. Reset mid-operation abandons the transfer; late memory returns are discarded and no done is issued.
- States:
  - IDLE: waits for a start.
  - EVICT: issues 4 writes.
  - FILL: issues 4 reads.
  - DRAIN: waits for outstanding returns.
  - DONE: one cycle.
- IDLE transitions (start sampled in IDLE):
  - start_evict → EVICT.
  - start_fill only → FILL.
  - Both asserted → EVICT, then FILL.
  - Addresses are latched at the start. Starts while busy are ignored.
- Word index k goes 0..3 in order; issue address = {line[ADDR_W-1:3], k[1:0], 1'b0}.
- Issue condition: !mem_stall && !mem_busy[k]. Otherwise hold k, mem_addr and mem_wr_data, and keep mem_rd/mem_wr low. At most one issue per cycle.
- EVICT word k:
  - cache_offset = {k,0}.
  - mem_wr_data = cache_rd_data.
  - mem_wr = 1 when the issue condition holds.
  - After k=3 issues: go to FILL if a fill is pending, else DONE.
- FILL word k:
  - mem_rd = 1 when the issue condition holds.
  - The issue pushes {valid,k} into a MEM_LAT-deep shift register.
  - After k=3 issues → DRAIN.
- Returns (FILL and DRAIN): when the pipeline head is valid, cache_wr_en = 1, cache_offset = {k_head,0}, cache_wr_data = mem_rd_data. cache_offset drives the return word index while a return is valid; no issue-side conflict exists because EVICT never overlaps returns.
- DRAIN → DONE in the cycle after the last return is written.
- DONE: done = 1, err = sticky error flag, → IDLE. The error flag sets on any mem_err while busy and clears on entry to IDLE.
- Latency, no stalls, MEM_LAT = 2, start at cycle 0:
  - Fill: reads in cycles 1-4, cache writes in cycles 3-6, done in cycle 7.
  - Evict: writes in cycles 1-4, done in cycle 5.
  - Evict+fill: writes 1-4, reads 5-8, cache writes 7-10, done in cycle 11.
- Each stall or busy cycle adds exactly one cycle to every later event.
- Never assert mem_rd and mem_wr together, and never issue to a bank whose busy bit is set.

Test Plan:
- Fill only: fill_addr = 0x1238, memory word at 0x123C = 0xBEEF → mem_rd in cycles 1-4 at 0x1238/A/C/E; cache_wr_en with offset 4 and data 0xBEEF in cycle 5; done in cycle 7, err = 0.
- Evict+fill: evict_addr = 0x4000, fill_addr = 0x8000, cache words AAAA/BBBB/CCCC/DDDD → mem_wr to 0x4000-0x4006 with those data in cycles 1-4; reads from 0x8000 in cycles 5-8; done in cycle 11.
- Bank busy: mem_busy = 4'b0100 for 3 cycles during a fill → word 2 is held (mem_rd low) for 3 cycles, other words are unaffected in order, done in cycle 10.
- Start ignored: pulse start_fill in cycle 2 of a running fill → no extra reads; single done.
- Reset mid-fill: rst asserted in cycle 4 → all outputs 0 immediately; no cache_wr_en or done after release; a new fill completes normally.
- Memory error: mem_err pulsed in cycle 3 of an evict → err = 1 together with done in cycle 5; the next transfer reports err = 0.
